// File: rtl/keypad_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_entry_ctrl_if
//  Purpose  : Bundle of keypad-decoder inputs, LCD character-writer handshake
//             and committed-entry handoff used by keypad_entry_ctrl.
//  Ports    : (interface signals)
//             LCD_DATA[7:0]  decoder ASCII, low nibble = digit when CHK=1
//             CHK            decoder: exactly one digit key pressed
//             star, sharp    raw '*' / '#' key levels
//             LCD_BUSY       LCD writer busy
//             LCD_WR         one-cycle write strobe
//             LCD_CHAR[7:0]  character qualified by LCD_WR
//             ENTRY          packed BCD, first key in the lowest nibble
//             ENTRY_LEN[4:0] digits currently held
//             ENTRY_VALID    committed entry available until ENTRY_ACK
//             ENTRY_ACK      consumer has taken ENTRY
//  Modports : slave  - the entry controller
//             master - the keypad/LCD/consumer environment
//  Revision : 1.0 - initial release
// ============================================================================
interface keypad_entry_ctrl_if #(
  parameter int MAX_DIGITS = 16
) ();
  logic [7:0]              LCD_DATA;
  logic                    CHK;
  logic                    star;
  logic                    sharp;
  logic                    LCD_BUSY;
  logic                    LCD_WR;
  logic [7:0]              LCD_CHAR;
  logic [4*MAX_DIGITS-1:0] ENTRY;
  logic [4:0]              ENTRY_LEN;
  logic                    ENTRY_VALID;
  logic                    ENTRY_ACK;

  modport slave (
    input  LCD_DATA, CHK, star, sharp, LCD_BUSY, ENTRY_ACK,
    output LCD_WR, LCD_CHAR, ENTRY, ENTRY_LEN, ENTRY_VALID
  );

  modport master (
    output LCD_DATA, CHK, star, sharp, LCD_BUSY, ENTRY_ACK,
    input  LCD_WR, LCD_CHAR, ENTRY, ENTRY_LEN, ENTRY_VALID
  );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_entry_ctrl
//  Purpose  : Debounces keypad decoder activity, turns each press into a
//             single event, collects up to MAX_DIGITS digits into a packed
//             BCD buffer, echoes accepted keys to the LCD writer and hands a
//             committed entry to a consumer with a VALID/ACK handshake.
//             '*' is backspace, '#' is enter.
//  Ports    : CLK  - system clock, rising edge
//             RST  - synchronous active-high reset
//             bus  - keypad_entry_ctrl_if.slave (decoder inputs, LCD write
//                    strobe/char, ENTRY/ENTRY_LEN/ENTRY_VALID/ENTRY_ACK)
//  Params   : MAX_DIGITS - buffer depth in digits (1..31)
//             DEB_CYCLES - identical samples needed for a stable key (>=2)
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  keypad_entry_ctrl_if.slave     bus
);

  localparam int                 c_CNT_W    = $clog2(DEB_CYCLES);
  localparam int                 c_IDX_W    = $clog2(4 * MAX_DIGITS);
  localparam logic [c_CNT_W-1:0] c_DEB_PRE  = c_CNT_W'(DEB_CYCLES - 2);
  localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEB_CYCLES - 1);
  localparam logic [4:0]         c_MAX_LEN  = 5'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Debounce / event extraction
  // --------------------------------------------------------------------------
  logic [6:0]         w_code;
  logic [2:0]         w_keys;
  logic               w_same;
  logic               w_stable;
  logic [6:0]         r_prev_code;
  logic [c_CNT_W-1:0] r_deb_cnt;
  logic               r_pressed;
  logic               r_ev_digit;
  logic               r_ev_star;
  logic               r_ev_sharp;
  logic [7:0]         r_ev_char;

  assign w_code = {bus.sharp, bus.star, bus.CHK, bus.LCD_DATA[3:0]};
  assign w_keys = {bus.sharp, bus.star, bus.CHK};
  assign w_same = (w_code == r_prev_code);
  // True on the cycle whose sample brings the run of identical samples to
  // DEB_CYCLES (counter reaching DEB_CYCLES-1) and on every later cycle the
  // code stays unchanged; the press latch turns that into a single event.
  assign w_stable = w_same && (r_deb_cnt >= c_DEB_PRE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev_code <= 7'd0;
      r_deb_cnt   <= '0;
      r_pressed   <= 1'b0;
      r_ev_digit  <= 1'b0;
      r_ev_star   <= 1'b0;
      r_ev_sharp  <= 1'b0;
      r_ev_char   <= 8'h00;
    end else begin
      r_prev_code <= w_code;
      r_ev_digit  <= 1'b0;
      r_ev_star   <= 1'b0;
      r_ev_sharp  <= 1'b0;

      if (!w_same) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt != c_DEB_LAST) begin
        r_deb_cnt <= r_deb_cnt + c_CNT_W'(1);
      end

      if (w_stable) begin
        if (w_code == 7'd0) begin
          r_pressed <= 1'b0;
        end else if (!r_pressed) begin
          // Any stable non-zero code arms the latch, but only a single key
          // type produces an event; multi-key codes are swallowed.
          r_pressed  <= 1'b1;
          r_ev_digit <= (w_keys == 3'b001);
          r_ev_star  <= (w_keys == 3'b010);
          r_ev_sharp <= (w_keys == 3'b100);
          r_ev_char  <= bus.LCD_DATA;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entry FSM with registered outputs
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic                    r_lcd_wr;
  logic [7:0]              r_lcd_char;
  logic [4*MAX_DIGITS-1:0] r_entry;
  logic [4:0]              r_len;
  logic                    r_valid;
  logic [4:0]              w_len_dec;
  logic [c_IDX_W-1:0]      w_put_lsb;
  logic [c_IDX_W-1:0]      w_del_lsb;

  assign w_len_dec = r_len - 5'd1;
  assign w_put_lsb = c_IDX_W'({r_len, 2'b00});
  assign w_del_lsb = c_IDX_W'({w_len_dec, 2'b00});

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_lcd_wr   <= 1'b0;
      r_lcd_char <= 8'h00;
      r_entry    <= '0;
      r_len      <= 5'd0;
      r_valid    <= 1'b0;
    end else begin
      r_lcd_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_ev_digit) begin
            if (r_len < c_MAX_LEN) begin
              r_entry[w_put_lsb +: 4] <= r_ev_char[3:0];
              r_len                   <= r_len + 5'd1;
              r_lcd_char              <= r_ev_char;
              r_state                 <= S_WRITE;
            end
          end else if (r_ev_star) begin
            if (r_len != 5'd0) begin
              r_entry[w_del_lsb +: 4] <= 4'h0;
              r_len                   <= w_len_dec;
              r_lcd_char              <= 8'h08;
              r_state                 <= S_WRITE;
            end
          end else if (r_ev_sharp) begin
            if (r_len != 5'd0) begin
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end
        end

        S_WRITE: begin
          if (!bus.LCD_BUSY) begin
            r_lcd_wr <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        S_HOLD: begin
          if (bus.ENTRY_ACK) begin
            r_valid    <= 1'b0;
            r_entry    <= '0;
            r_len      <= 5'd0;
            r_lcd_char <= 8'h0C;
            r_state    <= S_WRITE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.LCD_WR      = r_lcd_wr;
  assign bus.LCD_CHAR    = r_lcd_char;
  assign bus.ENTRY       = r_entry;
  assign bus.ENTRY_LEN   = r_len;
  assign bus.ENTRY_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_entry_ctrl
//  Purpose  : Directed self-checking bench for keypad_entry_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_ctrl;

  localparam int MAXD = 16;
  localparam int DEB  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  keypad_entry_ctrl_if #(.MAX_DIGITS(MAXD)) kif ();

  keypad_entry_ctrl #(
    .MAX_DIGITS(MAXD),
    .DEB_CYCLES(DEB)
  ) u_dut (
    .CLK(CLK),
    .RST(RST),
    .bus(kif)
  );

  int         cyc         = 0;
  int         wr_count    = 0;
  int         last_wr_cyc = 0;
  logic [7:0] last_char   = 8'h00;
  logic [7:0] q_chars[$];
  int         n_checks    = 0;
  int         n_fail      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (kif.LCD_WR === 1'b1) begin
      wr_count    = wr_count + 1;
      last_char   = kif.LCD_CHAR;
      last_wr_cyc = cyc;
      q_chars.push_back(kif.LCD_CHAR);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic set_keys(input logic [7:0] data, input logic chk, input logic st, input logic sh);
    @(negedge CLK);
    kif.LCD_DATA = data;
    kif.CHK      = chk;
    kif.star     = st;
    kif.sharp    = sh;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic settle;
    @(negedge CLK);
    #1;
  endtask

  task automatic press(input logic [7:0] data, input logic chk, input logic st, input logic sh);
    set_keys(data, chk, st, sh);
    wait_cycles(10);
    set_keys(8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(8);
  endtask

  task automatic press_digit(input int d);
    press(8'(8'h30 + d), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply_reset;
    @(negedge CLK);
    RST           = 1'b1;
    kif.LCD_DATA  = 8'h00;
    kif.CHK       = 1'b0;
    kif.star      = 1'b0;
    kif.sharp     = 1'b0;
    kif.LCD_BUSY  = 1'b0;
    kif.ENTRY_ACK = 1'b0;
    wait_cycles(3);
    RST = 1'b0;
    wait_cycles(2);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset;
    wait_cycles(3);
    #1;
    n_checks++;
    if (kif.LCD_WR !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b expected 0", kif.LCD_WR); end
    n_checks++;
    if (kif.LCD_CHAR !== 8'h00) begin n_fail++; $display("FAIL reset_char: got %h expected 00", kif.LCD_CHAR); end
    n_checks++;
    if (kif.ENTRY !== 64'h0) begin n_fail++; $display("FAIL reset_entry: got %h expected 0", kif.ENTRY); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd0) begin n_fail++; $display("FAIL reset_len: got %0d expected 0", kif.ENTRY_LEN); end
    n_checks++;
    if (kif.ENTRY_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", kif.ENTRY_VALID); end
    @(negedge CLK);
    RST = 1'b0;
    wait_cycles(4);
    settle();
    n_checks++;
    if (wr_count !== 0) begin n_fail++; $display("FAIL reset_no_strobe: got %0d strobes expected 0", wr_count); end
  endtask

  task automatic test_single_digit;
    int w0;
    int t0;
    w0 = wr_count;
    set_keys(8'h35, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    wait_cycles(10);
    set_keys(8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(8);
    settle();
    n_checks++;
    if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL single_strobes: got %0d expected 1", wr_count - w0); end
    n_checks++;
    if (last_char !== 8'h35) begin n_fail++; $display("FAIL single_char: got %h expected 35", last_char); end
    n_checks++;
    if (last_wr_cyc - t0 !== DEB + 2) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", last_wr_cyc - t0, DEB + 2); end
    n_checks++;
    if (kif.ENTRY[3:0] !== 4'd5) begin n_fail++; $display("FAIL single_entry: got %h expected 5", kif.ENTRY[3:0]); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd1) begin n_fail++; $display("FAIL single_len: got %0d expected 1", kif.ENTRY_LEN); end
  endtask

  task automatic test_bounce;
    int w0;
    int t0;
    w0 = wr_count;
    set_keys(8'h37, 1'b1, 1'b0, 1'b0);
    set_keys(8'h37, 1'b0, 1'b0, 1'b0);
    set_keys(8'h37, 1'b1, 1'b0, 1'b0);
    set_keys(8'h37, 1'b0, 1'b0, 1'b0);
    set_keys(8'h37, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    wait_cycles(2);
    settle();
    n_checks++;
    if (wr_count !== w0) begin n_fail++; $display("FAIL bounce_early: got %0d strobes expected 0", wr_count - w0); end
    wait_cycles(8);
    set_keys(8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(8);
    settle();
    n_checks++;
    if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL bounce_strobes: got %0d expected 1", wr_count - w0); end
    n_checks++;
    if (last_wr_cyc - t0 !== DEB + 2) begin n_fail++; $display("FAIL bounce_latency: got %0d expected %0d", last_wr_cyc - t0, DEB + 2); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd2) begin n_fail++; $display("FAIL bounce_len: got %0d expected 2", kif.ENTRY_LEN); end
    n_checks++;
    if (kif.ENTRY[7:0] !== 8'h75) begin n_fail++; $display("FAIL bounce_entry: got %h expected 75", kif.ENTRY[7:0]); end
  endtask

  task automatic test_entry_commit;
    int          w0;
    int          w1;
    logic [31:0] got_chars;
    apply_reset();
    q_chars.delete();
    w0 = wr_count;
    press_digit(1);
    press_digit(2);
    press_digit(3);
    press(8'h00, 1'b0, 1'b1, 1'b0);
    press(8'h00, 1'b0, 1'b0, 1'b1);
    settle();
    got_chars = {q_chars[0], q_chars[1], q_chars[2], q_chars[3]};
    n_checks++;
    if (q_chars.size() !== 4) begin n_fail++; $display("FAIL commit_nchars: got %0d expected 4", q_chars.size()); end
    n_checks++;
    if (got_chars !== 32'h31323308) begin n_fail++; $display("FAIL commit_chars: got %h expected 31323308", got_chars); end
    n_checks++;
    if (kif.ENTRY !== 64'h21) begin n_fail++; $display("FAIL commit_entry: got %h expected 21", kif.ENTRY); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd2) begin n_fail++; $display("FAIL commit_len: got %0d expected 2", kif.ENTRY_LEN); end
    n_checks++;
    if (kif.ENTRY_VALID !== 1'b1) begin n_fail++; $display("FAIL commit_valid: got %b expected 1", kif.ENTRY_VALID); end

    // Keys during HOLD are discarded
    w1 = wr_count;
    press_digit(4);
    settle();
    n_checks++;
    if (wr_count !== w1) begin n_fail++; $display("FAIL hold_strobe: got %0d strobes expected 0", wr_count - w1); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd2 || kif.ENTRY !== 64'h21) begin n_fail++; $display("FAIL hold_frozen: got len %0d entry %h expected len 2 entry 21", kif.ENTRY_LEN, kif.ENTRY); end

    @(negedge CLK);
    kif.ENTRY_ACK = 1'b1;
    @(negedge CLK);
    kif.ENTRY_ACK = 1'b0;
    wait_cycles(5);
    settle();
    n_checks++;
    if (kif.ENTRY_VALID !== 1'b0) begin n_fail++; $display("FAIL ack_valid: got %b expected 0", kif.ENTRY_VALID); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd0 || kif.ENTRY !== 64'h0) begin n_fail++; $display("FAIL ack_clear: got len %0d entry %h expected 0 0", kif.ENTRY_LEN, kif.ENTRY); end
    n_checks++;
    if (wr_count - w1 !== 1) begin n_fail++; $display("FAIL ack_strobes: got %0d expected 1", wr_count - w1); end
    n_checks++;
    if (last_char !== 8'h0C) begin n_fail++; $display("FAIL ack_char: got %h expected 0C", last_char); end
  endtask

  task automatic test_full;
    int          w0;
    logic [63:0] exp_entry;
    apply_reset();
    w0        = wr_count;
    exp_entry = '0;
    for (int i = 0; i < MAXD; i++) begin
      press_digit(i % 10);
      exp_entry[4*i +: 4] = 4'(i % 10);
    end
    settle();
    n_checks++;
    if (kif.ENTRY_LEN !== 5'(MAXD)) begin n_fail++; $display("FAIL full_len: got %0d expected %0d", kif.ENTRY_LEN, MAXD); end
    n_checks++;
    if (kif.ENTRY !== exp_entry) begin n_fail++; $display("FAIL full_entry: got %h expected %h", kif.ENTRY, exp_entry); end
    n_checks++;
    if (wr_count - w0 !== MAXD) begin n_fail++; $display("FAIL full_strobes: got %0d expected %0d", wr_count - w0, MAXD); end

    w0 = wr_count;
    press_digit(9);
    settle();
    n_checks++;
    if (wr_count !== w0) begin n_fail++; $display("FAIL overflow_strobe: got %0d strobes expected 0", wr_count - w0); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'(MAXD) || kif.ENTRY !== exp_entry) begin n_fail++; $display("FAIL overflow_entry: got len %0d entry %h", kif.ENTRY_LEN, kif.ENTRY); end

    apply_reset();
    w0 = wr_count;
    press(8'h00, 1'b0, 1'b1, 1'b0);
    settle();
    n_checks++;
    if (wr_count !== w0) begin n_fail++; $display("FAIL empty_star_strobe: got %0d strobes expected 0", wr_count - w0); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd0) begin n_fail++; $display("FAIL empty_star_len: got %0d expected 0", kif.ENTRY_LEN); end
  endtask

  task automatic test_busy;
    int w0;
    apply_reset();
    w0 = wr_count;
    @(negedge CLK);
    kif.LCD_BUSY = 1'b1;
    set_keys(8'h36, 1'b1, 1'b0, 1'b0);
    wait_cycles(6);
    set_keys(8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(6);
    press_digit(8);
    settle();
    n_checks++;
    if (wr_count !== w0) begin n_fail++; $display("FAIL busy_holdoff: got %0d strobes expected 0", wr_count - w0); end
    @(negedge CLK);
    kif.LCD_BUSY = 1'b0;
    wait_cycles(3);
    settle();
    n_checks++;
    if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL busy_strobes: got %0d expected 1", wr_count - w0); end
    n_checks++;
    if (last_char !== 8'h36) begin n_fail++; $display("FAIL busy_char: got %h expected 36", last_char); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd1 || kif.ENTRY !== 64'h6) begin n_fail++; $display("FAIL busy_discard: got len %0d entry %h expected 1 6", kif.ENTRY_LEN, kif.ENTRY); end
  endtask

  task automatic test_invalid;
    int w0;
    apply_reset();
    w0 = wr_count;
    press(8'h35, 1'b1, 1'b1, 1'b0);
    settle();
    n_checks++;
    if (wr_count !== w0) begin n_fail++; $display("FAIL invalid_strobe: got %0d strobes expected 0", wr_count - w0); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd0) begin n_fail++; $display("FAIL invalid_len: got %0d expected 0", kif.ENTRY_LEN); end
    press_digit(2);
    settle();
    n_checks++;
    if (wr_count - w0 !== 1 || last_char !== 8'h32) begin n_fail++; $display("FAIL after_invalid: got %0d strobes char %h expected 1 32", wr_count - w0, last_char); end
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd1) begin n_fail++; $display("FAIL after_invalid_len: got %0d expected 1", kif.ENTRY_LEN); end
  endtask

  task automatic test_reset_in_write;
    int w0;
    apply_reset();
    w0 = wr_count;
    @(negedge CLK);
    kif.LCD_BUSY = 1'b1;
    set_keys(8'h34, 1'b1, 1'b0, 1'b0);
    wait_cycles(8);
    #1;
    n_checks++;
    if (kif.ENTRY_LEN !== 5'd1) begin n_fail++; $display("FAIL rstwr_pre_len: got %0d expected 1", kif.ENTRY_LEN); end
    set_keys(8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    wait_cycles(2);
    RST = 1'b0;
    wait_cycles(1);
    kif.LCD_BUSY = 1'b0;
    wait_cycles(10);
    settle();
    n_checks++;
    if (wr_count !== w0) begin n_fail++; $display("FAIL rstwr_strobe: got %0d strobes expected 0", wr_count - w0); end
    n_checks++;
    if (kif.LCD_WR !== 1'b0 || kif.LCD_CHAR !== 8'h00) begin n_fail++; $display("FAIL rstwr_lcd: got wr %b char %h expected 0 00", kif.LCD_WR, kif.LCD_CHAR); end
    n_checks++;
    if (kif.ENTRY !== 64'h0 || kif.ENTRY_LEN !== 5'd0 || kif.ENTRY_VALID !== 1'b0) begin n_fail++; $display("FAIL rstwr_entry: got entry %h len %0d valid %b expected 0", kif.ENTRY, kif.ENTRY_LEN, kif.ENTRY_VALID); end
  endtask

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  initial begin
    kif.LCD_DATA  = 8'h00;
    kif.CHK       = 1'b0;
    kif.star      = 1'b0;
    kif.sharp     = 1'b0;
    kif.LCD_BUSY  = 1'b0;
    kif.ENTRY_ACK = 1'b0;
    RST           = 1'b1;

    test_reset();
    test_single_digit();
    test_bounce();
    test_entry_commit();
    test_full();
    test_busy();
    test_invalid();
    test_reset_in_write();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
